// File: rtl/server_rx_checker.sv
// Receive-side checker for 128-beat server test packets: filters on dst MAC, checks format, measures latency.
// Optional latency accumulator (o_lat_sum) is built only when SERVER_RX_LAT_ACC_EN is defined.
module server_rx_checker #(
  parameter logic [47:0] P_MY_PORT_MAC = 48'h8D_BC_5C_4A_00_01,
  parameter int unsigned P_PKT_LEN     = 128,
  parameter logic [15:0] P_ETH_TYPE    = 16'h0800
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [63:0] i_time_stamp,
  input  logic        rx_axis_tvalid,
  input  logic [63:0] rx_axis_tdata,
  input  logic        rx_axis_tlast,
  input  logic [7:0]  rx_axis_tkeep,
  input  logic        rx_axis_tuser,
  output logic        rx_axis_tready,
  output logic        o_pkt_valid,
  output logic [47:0] o_src_mac,
  output logic [31:0] o_latency,
  output logic [31:0] o_rx_pkt_cnt,
  output logic [15:0] o_err_cnt,
  output logic [15:0] o_drop_cnt,
  output logic [31:0] o_max_latency,
  output logic [63:0] o_lat_sum
);

  localparam logic [1:0] S_HDR0    = 2'd0;
  localparam logic [1:0] S_HDR1    = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_DROP    = 2'd3;

  localparam logic [15:0] LAST_IDX  = 16'(P_PKT_LEN - 1);
  localparam logic [15:0] FIRST_PLD = 16'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic        err_flag_q, err_flag_d;
  logic        drop_flag_q, drop_flag_d;
  logic        tready_q, tready_d;
  logic [15:0] src_hi_q, src_hi_d;
  logic [31:0] src_lo_q, src_lo_d;
  logic [63:0] first_ts_q, first_ts_d;
  logic [63:0] prev_ts_q, prev_ts_d;
  logic        pkt_valid_q, pkt_valid_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic [31:0] latency_q, latency_d;
  logic [31:0] rx_cnt_q, rx_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] max_lat_q, max_lat_d;

  logic        beat;
  logic        fmt_err;
  logic        len_err;
  logic        end_good, end_err, end_drop;
  logic [63:0] first_ts_eff;
  logic [63:0] lat_full;
  logic [31:0] lat_clamped;

  assign beat    = rx_axis_tvalid & tready_q;
  assign fmt_err = (rx_axis_tkeep != 8'hFF) | rx_axis_tuser;
  // tlast must coincide exactly with the last beat index; either mismatch is a length error.
  assign len_err = rx_axis_tlast ^ (beat_cnt_q == LAST_IDX);

  assign first_ts_eff = (beat_cnt_q == FIRST_PLD) ? rx_axis_tdata : first_ts_q;
  assign lat_full     = i_time_stamp - first_ts_eff;
  assign lat_clamped  = (|lat_full[63:32]) ? 32'hFFFF_FFFF : lat_full[31:0];

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    err_flag_d  = err_flag_q;
    drop_flag_d = drop_flag_q;
    tready_d    = 1'b1;
    src_hi_d    = src_hi_q;
    src_lo_d    = src_lo_q;
    first_ts_d  = first_ts_q;
    prev_ts_d   = prev_ts_q;
    end_good    = 1'b0;
    end_err     = 1'b0;
    end_drop    = 1'b0;

    if (beat) begin
      if (rx_axis_tlast)              beat_cnt_d = 16'd0;
      else if (beat_cnt_q != 16'hFFFF) beat_cnt_d = beat_cnt_q + 16'd1;

      case (state_q)
        S_HDR0: begin
          if (rx_axis_tdata[63:16] == P_MY_PORT_MAC) begin
            src_hi_d = rx_axis_tdata[15:0];
            if (rx_axis_tlast) begin
              end_err = 1'b1;
            end else begin
              err_flag_d = fmt_err | len_err;
              state_d    = S_HDR1;
            end
          end else if (rx_axis_tlast) begin
            end_drop = 1'b1;
          end else begin
            drop_flag_d = 1'b1;
            state_d     = S_DROP;
          end
        end
        S_HDR1: begin
          src_lo_d = rx_axis_tdata[63:32];
          if (rx_axis_tlast) begin
            end_err = 1'b1;
            state_d = S_HDR0;
          end else begin
            err_flag_d = err_flag_q | fmt_err | len_err |
                         (rx_axis_tdata[31:16] != P_ETH_TYPE) | (rx_axis_tdata[15:0] != 16'h0);
            state_d    = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          prev_ts_d = rx_axis_tdata;
          if (beat_cnt_q == FIRST_PLD) first_ts_d = rx_axis_tdata;
          if (rx_axis_tlast) begin
            if (err_flag_q | fmt_err | len_err |
                ((beat_cnt_q != FIRST_PLD) && (rx_axis_tdata < prev_ts_q)))
              end_err = 1'b1;
            else
              end_good = 1'b1;
            state_d = S_HDR0;
          end else begin
            err_flag_d = err_flag_q | fmt_err | len_err |
                         ((beat_cnt_q != FIRST_PLD) && (rx_axis_tdata < prev_ts_q));
            // Overlong packet: swallow the rest, it is counted once when tlast finally arrives.
            if (beat_cnt_q == LAST_IDX) state_d = S_DROP;
          end
        end
        default: begin
          if (rx_axis_tlast) begin
            if (drop_flag_q) end_drop = 1'b1;
            else             end_err  = 1'b1;
            state_d = S_HDR0;
          end
        end
      endcase

      if (rx_axis_tlast) begin
        err_flag_d  = 1'b0;
        drop_flag_d = 1'b0;
      end
    end
  end

  always_comb begin
    pkt_valid_d = end_good;
    src_mac_d   = src_mac_q;
    latency_d   = latency_q;
    rx_cnt_d    = rx_cnt_q;
    err_cnt_d   = err_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    max_lat_d   = max_lat_q;
    if (end_good) begin
      src_mac_d = {src_hi_q, src_lo_q};
      latency_d = lat_clamped;
      if (rx_cnt_q != '1) rx_cnt_d = rx_cnt_q + 32'd1;
      if (lat_clamped > max_lat_q) max_lat_d = lat_clamped;
    end
    if (end_err  && err_cnt_q  != '1) err_cnt_d  = err_cnt_q + 16'd1;
    if (end_drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_HDR0;
      beat_cnt_q  <= '0;
      err_flag_q  <= 1'b0;
      drop_flag_q <= 1'b0;
      tready_q    <= 1'b0;
      src_hi_q    <= '0;
      src_lo_q    <= '0;
      first_ts_q  <= '0;
      prev_ts_q   <= '0;
      pkt_valid_q <= 1'b0;
      src_mac_q   <= '0;
      latency_q   <= '0;
      rx_cnt_q    <= '0;
      err_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      max_lat_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      err_flag_q  <= err_flag_d;
      drop_flag_q <= drop_flag_d;
      tready_q    <= tready_d;
      src_hi_q    <= src_hi_d;
      src_lo_q    <= src_lo_d;
      first_ts_q  <= first_ts_d;
      prev_ts_q   <= prev_ts_d;
      pkt_valid_q <= pkt_valid_d;
      src_mac_q   <= src_mac_d;
      latency_q   <= latency_d;
      rx_cnt_q    <= rx_cnt_d;
      err_cnt_q   <= err_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      max_lat_q   <= max_lat_d;
    end
  end

`ifdef SERVER_RX_LAT_ACC_EN
  logic [63:0] lat_sum_q, lat_sum_d;
  logic [64:0] lat_sum_add;

  assign lat_sum_add = {1'b0, lat_sum_q} + {33'd0, lat_clamped};

  always_comb begin
    lat_sum_d = lat_sum_q;
    if (end_good) lat_sum_d = lat_sum_add[64] ? 64'hFFFF_FFFF_FFFF_FFFF : lat_sum_add[63:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) lat_sum_q <= '0;
    else          lat_sum_q <= lat_sum_d;
  end

  assign o_lat_sum = lat_sum_q;
`else
  assign o_lat_sum = 64'd0;
`endif

  assign rx_axis_tready = tready_q;
  assign o_pkt_valid    = pkt_valid_q;
  assign o_src_mac      = src_mac_q;
  assign o_latency      = latency_q;
  assign o_rx_pkt_cnt   = rx_cnt_q;
  assign o_err_cnt      = err_cnt_q;
  assign o_drop_cnt     = drop_cnt_q;
  assign o_max_latency  = max_lat_q;

endmodule

// File: tb/tb_server_rx_checker.sv
// Directed bench for server_rx_checker: good, foreign, malformed, back-to-back, reset and wrap packets.
module tb_server_rx_checker;

  localparam logic [47:0] MY_MAC  = 48'h8D_BC_5C_4A_00_01;
  localparam logic [47:0] SRC_MAC = 48'h8D_BC_5C_4A_01_02;

  logic        clk;
  logic        rst_n;
  logic [63:0] time_stamp;
  logic        tvalid;
  logic [63:0] tdata;
  logic        tlast;
  logic [7:0]  tkeep;
  logic        tuser;
  logic        tready;
  logic        pkt_valid;
  logic [47:0] src_mac;
  logic [31:0] latency;
  logic [31:0] rx_cnt;
  logic [15:0] err_cnt;
  logic [15:0] drop_cnt;
  logic [31:0] max_lat;
  logic [63:0] lat_sum;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int pulse_base;

  server_rx_checker dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_time_stamp   (time_stamp),
    .rx_axis_tvalid (tvalid),
    .rx_axis_tdata  (tdata),
    .rx_axis_tlast  (tlast),
    .rx_axis_tkeep  (tkeep),
    .rx_axis_tuser  (tuser),
    .rx_axis_tready (tready),
    .o_pkt_valid    (pkt_valid),
    .o_src_mac      (src_mac),
    .o_latency      (latency),
    .o_rx_pkt_cnt   (rx_cnt),
    .o_err_cnt      (err_cnt),
    .o_drop_cnt     (drop_cnt),
    .o_max_latency  (max_lat),
    .o_lat_sum      (lat_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The pulse is one full cycle wide, so each one is seen at exactly one falling edge.
  always @(negedge clk) if (pkt_valid === 1'b1) pulses++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pulse_base = pulses;
  endtask

  // Sends beats 0..n_send-1 of a len-beat packet; tlast on beat len-1, i_time_stamp=last_ts there.
  task automatic send_pkt(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] eth,
                          input int len, input int n_send, input logic [63:0] ts0,
                          input logic [63:0] last_ts, input int tuser_beat, input bit hold);
    for (int i = 0; i < n_send; i++) begin
      @(negedge clk);
      tvalid = 1'b1;
      tkeep  = 8'hFF;
      tuser  = (i == tuser_beat);
      tlast  = (i == len - 1);
      if (i == 0)      tdata = {dst, src[47:32]};
      else if (i == 1) tdata = {src[31:0], eth, 16'h0};
      else             tdata = ts0 + 64'(i - 2);
      time_stamp = (i == len - 1) ? last_ts : ts0 + 64'(i);
    end
    if (!hold) begin
      @(negedge clk);
      tvalid = 1'b0;
      tlast  = 1'b0;
      tuser  = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    time_stamp = '0;
    tvalid     = 1'b0;
    tdata      = '0;
    tlast      = 1'b0;
    tkeep      = 8'hFF;
    tuser      = 1'b0;
    pulse_base = 0;

    #12;
    check("rst_tready",  64'(tready),   64'd0);
    check("rst_valid",   64'(pkt_valid), 64'd0);
    check("rst_rx_cnt",  64'(rx_cnt),   64'd0);
    check("rst_err_cnt", 64'(err_cnt),  64'd0);
    check("rst_max_lat", 64'(max_lat),  64'd0);
    check("rst_lat_sum", lat_sum,       64'd0);
    do_reset();
    check("tready_up", 64'(tready), 64'd1);

    // 1: good packet, latency 1200-1000
    send_pkt(MY_MAC, SRC_MAC, 16'h0800, 128, 128, 64'd1000, 64'd1200, -1, 1'b0);
    check("t1_pulses",  64'(pulses - pulse_base), 64'd1);
    check("t1_src_mac", 64'(src_mac),  64'(SRC_MAC));
    check("t1_latency", 64'(latency),  64'd200);
    check("t1_rx_cnt",  64'(rx_cnt),   64'd1);
    check("t1_max_lat", 64'(max_lat),  64'd200);
    check("t1_err_cnt", 64'(err_cnt),  64'd0);

    // 2: foreign destination
    do_reset();
    send_pkt(48'h8D_BC_5C_4A_00_02, SRC_MAC, 16'h0800, 128, 128, 64'd1000, 64'd1200, -1, 1'b0);
    check("t2_drop_cnt", 64'(drop_cnt), 64'd1);
    check("t2_pulses",   64'(pulses - pulse_base), 64'd0);
    check("t2_rx_cnt",   64'(rx_cnt),   64'd0);
    check("t2_err_cnt",  64'(err_cnt),  64'd0);

    // 3: bad ethertype, short packet, tuser error, then overlong packet
    do_reset();
    send_pkt(MY_MAC, SRC_MAC, 16'h86DD, 128, 128, 64'd1000, 64'd1200, -1, 1'b0);
    send_pkt(MY_MAC, SRC_MAC, 16'h0800, 100, 100, 64'd1000, 64'd1200, -1, 1'b0);
    send_pkt(MY_MAC, SRC_MAC, 16'h0800, 128, 128, 64'd1000, 64'd1200, 50, 1'b0);
    check("t3_err_cnt", 64'(err_cnt), 64'd3);
    check("t3_rx_cnt",  64'(rx_cnt),  64'd0);
    check("t3_pulses",  64'(pulses - pulse_base), 64'd0);
    check("t3_latency", 64'(latency), 64'd0);
    send_pkt(MY_MAC, SRC_MAC, 16'h0800, 130, 130, 64'd1000, 64'd1300, -1, 1'b0);
    check("t3_long_err", 64'(err_cnt), 64'd4);
    send_pkt(MY_MAC, SRC_MAC, 16'h0800, 128, 128, 64'd3000, 64'd3050, -1, 1'b0);
    check("t3_recover_rx",  64'(rx_cnt),  64'd1);
    check("t3_recover_lat", 64'(latency), 64'd50);
    check("t3_drop_cnt",    64'(drop_cnt), 64'd0);

    // 4: back-to-back good packets, latencies 200 then 150
    do_reset();
    send_pkt(MY_MAC, SRC_MAC, 16'h0800, 128, 128, 64'd1000, 64'd1200, -1, 1'b1);
    send_pkt(MY_MAC, 48'h0A_0B_0C_0D_0E_0F, 16'h0800, 128, 128, 64'd2000, 64'd2150, -1, 1'b0);
    check("t4_pulses",  64'(pulses - pulse_base), 64'd2);
    check("t4_rx_cnt",  64'(rx_cnt),  64'd2);
    check("t4_latency", 64'(latency), 64'd150);
    check("t4_src_mac", 64'(src_mac), 64'h0A0B_0C0D_0E0F);
    check("t4_max_lat", 64'(max_lat), 64'd200);
`ifdef SERVER_RX_LAT_ACC_EN
    check("t4_lat_sum", lat_sum, 64'd350);
`else
    check("t4_lat_sum", lat_sum, 64'd0);
`endif

    // 5: asynchronous reset after 60 beats, then a fresh good packet
    do_reset();
    send_pkt(MY_MAC, SRC_MAC, 16'h0800, 128, 60, 64'd1000, 64'd1200, -1, 1'b1);
    @(posedge clk);
    #2;
    rst_n  = 1'b0;
    tvalid = 1'b0;
    #1;
    check("t5_async_tready", 64'(tready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pulse_base = pulses;
    send_pkt(MY_MAC, SRC_MAC, 16'h0800, 128, 128, 64'd4000, 64'd4100, -1, 1'b0);
    check("t5_rx_cnt",  64'(rx_cnt),  64'd1);
    check("t5_err_cnt", 64'(err_cnt), 64'd0);
    check("t5_latency", 64'(latency), 64'd100);

    // 6: tlast timestamp one below first_ts -> clamped latency, still good
    do_reset();
    send_pkt(MY_MAC, SRC_MAC, 16'h0800, 128, 128, 64'd5000, 64'd4999, -1, 1'b0);
    check("t6_latency", 64'(latency), 64'hFFFF_FFFF);
    check("t6_rx_cnt",  64'(rx_cnt),  64'd1);
    check("t6_err_cnt", 64'(err_cnt), 64'd0);
    check("t6_max_lat", 64'(max_lat), 64'hFFFF_FFFF);
`ifdef SERVER_RX_LAT_ACC_EN
    check("t6_lat_sum", lat_sum, 64'hFFFF_FFFF);
`else
    check("t6_lat_sum", lat_sum, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
